cmd_serializer: RTL and testbench

//  Transmit side of the SD CMD line: frames a 48-bit SD command from index + argument,

---
 rtl/cmd_serializer.sv | 142 ++++++++++++++
 tb/tb_cmd_serializer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_serializer.sv
`default_nettype none
// ============================================================================
// Module  : cmd_serializer
// Purpose : SD CMD-line transmitter; frames index + argument, appends CRC7 and
//           shifts the 48-bit frame out MSB-first followed by Ncc trailer bits.
// Rev     : 1.0  initial release
// ============================================================================
module cmd_serializer #(
  parameter int unsigned POST_BITS  = 8,
  parameter bit          IDLE_LEVEL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  output logic        cmd_out,
  output logic        cmd_oe,
  output logic        busy,
  output logic        done,
  output logic [6:0]  crc_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_TRAIL = 2'd2
  } state_t;

  localparam logic [5:0] C_LAST_BIT = 6'd47;
  localparam logic [5:0] C_POST     = 6'(POST_BITS);
  localparam logic [6:0] C_CRC_POLY = 7'h09;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [39:0] sr_q, sr_d;
  logic [6:0]  crc_q, crc_d;
  logic [6:0]  crc_out_q, crc_out_d;
  logic        cmd_out_q, cmd_out_d;
  logic        cmd_oe_q, cmd_oe_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [2:0]  crc_idx;
  logic        crc_fb;

  // Frame bits 7..1 carry CRC bits 6..0, so the CRC index is counter-1.
  assign crc_idx = cnt_q[2:0] - 3'd1;
  assign crc_fb  = sr_q[39] ^ crc_q[6];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    crc_d     = crc_q;
    crc_out_d = crc_out_q;
    cmd_out_d = IDLE_LEVEL;
    cmd_oe_d  = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sr_d    = {1'b0, 1'b1, cmd_index, cmd_arg};
          crc_d   = 7'd0;
          cnt_d   = C_LAST_BIT;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        cmd_oe_d = 1'b1;
        busy_d   = 1'b1;
        if (cnt_q >= 6'd8) begin
          cmd_out_d = sr_q[39];
          sr_d      = {sr_q[38:0], 1'b0};
          crc_d     = {crc_q[5:0], 1'b0} ^ (crc_fb ? C_CRC_POLY : 7'd0);
        end else if (cnt_q != 6'd0) begin
          cmd_out_d = crc_q[crc_idx];
        end else begin
          cmd_out_d = 1'b1;
        end
        // With no trailer the TRAIL visit only produces the done cycle.
        if (cnt_q == 6'd0) begin
          cnt_d   = C_POST;
          state_d = ST_TRAIL;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end

      ST_TRAIL: begin
        if (cnt_q == 6'd0) begin
          done_d    = 1'b1;
          crc_out_d = crc_q;
          state_d   = ST_IDLE;
        end else begin
          cmd_out_d = 1'b1;
          cmd_oe_d  = 1'b1;
          busy_d    = 1'b1;
          cnt_d     = cnt_q - 6'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 6'd0;
      sr_q      <= 40'd0;
      crc_q     <= 7'd0;
      crc_out_q <= 7'd0;
      cmd_out_q <= IDLE_LEVEL;
      cmd_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      crc_q     <= crc_d;
      crc_out_q <= crc_out_d;
      cmd_out_q <= cmd_out_d;
      cmd_oe_q  <= cmd_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign cmd_out = cmd_out_q;
  assign cmd_oe  = cmd_oe_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign crc_out = crc_out_q;

endmodule
`default_nettype wire

// File: tb/tb_cmd_serializer.sv
`default_nettype none
// ============================================================================
// Module  : tb_cmd_serializer
// Purpose : Self-checking bench for cmd_serializer (POST_BITS=8 and =0 builds).
// Rev     : 1.0  initial release
// ============================================================================
module tb_cmd_serializer;

  localparam int P_A = 8;
  localparam int P_B = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  cmd_index = 6'd0;
  logic [31:0] cmd_arg = 32'd0;
  logic        cmd_out [2];
  logic        cmd_oe  [2];
  logic        busy    [2];
  logic        done    [2];
  logic [6:0]  crc_out [2];

  int          vectors = 0;
  int          miscompares = 0;
  int          pos [2];
  logic [47:0] fr [2];
  logic [6:0]  crc_exp [2];
  logic [47:0] cap;
  int          cyc = 0;
  int          done_cyc [2];

  always #5 clk = ~clk;

  cmd_serializer #(.POST_BITS(P_A), .IDLE_LEVEL(1'b1)) dut_a (
    .clk(clk), .reset(reset), .start(start), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
    .cmd_out(cmd_out[0]), .cmd_oe(cmd_oe[0]), .busy(busy[0]), .done(done[0]),
    .crc_out(crc_out[0])
  );

  cmd_serializer #(.POST_BITS(P_B), .IDLE_LEVEL(1'b1)) dut_b (
    .clk(clk), .reset(reset), .start(start), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
    .cmd_out(cmd_out[1]), .cmd_oe(cmd_oe[1]), .busy(busy[1]), .done(done[1]),
    .crc_out(crc_out[1])
  );

  function automatic int pb(input int d);
    return (d == 0) ? P_A : P_B;
  endfunction

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1 (long division).
  function automatic logic [47:0] build_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] body;
    logic [46:0] v;
    logic [46:0] g;
    body = {2'b01, idx, arg};
    v = {body, 7'd0};
    for (int i = 46; i >= 7; i--) begin
      if (v[i]) begin
        g = 47'(8'h89) << (i - 7);
        v = v ^ g;
      end
    end
    return {body, v[6:0], 1'b1};
  endfunction

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Timeline model: pos = cycles since the accepting edge, -1 when idle.
  task automatic model_step(input int d);
    int last;
    last = 49 + pb(d);
    if (!reset) begin
      pos[d] = -1;
      crc_exp[d] = 7'd0;
    end else if (pos[d] < 0 || pos[d] == last) begin
      if (start) begin
        pos[d] = 0;
        fr[d] = build_frame(cmd_index, cmd_arg);
      end else begin
        pos[d] = -1;
      end
    end else begin
      pos[d]++;
      if (pos[d] == last) crc_exp[d] = fr[d][7:1];
    end
  endtask

  task automatic check_outputs(input int d);
    int p;
    int last;
    logic eo, eoe, ed, eb;
    p = pos[d];
    last = 49 + pb(d);
    eo = 1'b1; eoe = 1'b0; ed = 1'b0; eb = 1'b0;
    if (p >= 1 && p <= 48) begin
      eo = fr[d][48 - p]; eoe = 1'b1; eb = 1'b1;
    end else if (p > 48 && p < last) begin
      eoe = 1'b1; eb = 1'b1;
    end else if (p == last) begin
      ed = 1'b1;
    end
    chk($sformatf("dut%0d cmd_out pos=%0d", d, p), 48'(cmd_out[d]), 48'(eo));
    chk($sformatf("dut%0d cmd_oe pos=%0d", d, p), 48'(cmd_oe[d]), 48'(eoe));
    chk($sformatf("dut%0d done pos=%0d", d, p), 48'(done[d]), 48'(ed));
    if (p != 0) chk($sformatf("dut%0d busy pos=%0d", d, p), 48'(busy[d]), 48'(eb));
    if (p < 0 || p == last) chk($sformatf("dut%0d crc_out", d), 48'(crc_out[d]), 48'(crc_exp[d]));
    if (d == 0 && p >= 1 && p <= 48) cap[48 - p] = cmd_out[0];
    if (done[d] === 1'b1) done_cyc[d] = cyc;
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) model_step(d);
    #1;
    for (int d = 0; d < 2; d++) check_outputs(d);
  endtask

  task automatic send(input logic [5:0] idx, input logic [31:0] arg);
    start = 1'b1;
    cmd_index = idx;
    cmd_arg = arg;
    cycle();
    start = 1'b0;
  endtask

  task automatic run_until_idle();
    int n;
    n = 0;
    while ((pos[0] >= 0 || pos[1] >= 0) && n < 300) begin
      cmd_index = 6'($urandom);
      cmd_arg = $urandom;
      cycle();
      n++;
    end
    vectors++;
    assert (n < 300) else begin
      miscompares++;
      $error("FAIL idle_timeout observed=%0d cycles expected<300", n);
    end
  endtask

  task automatic known_frame(input logic [5:0] idx, input logic [31:0] arg,
                             input logic [47:0] exp_frame, input logic [6:0] exp_crc);
    int k;
    send(idx, arg);
    k = cyc;
    run_until_idle();
    chk($sformatf("frame idx=%0d", idx), cap, exp_frame);
    chk($sformatf("crc_out idx=%0d", idx), 48'(crc_out[0]), 48'(exp_crc));
    chk($sformatf("done latency P8 idx=%0d", idx), 48'(done_cyc[0] - k), 48'(49 + P_A));
    chk($sformatf("done latency P0 idx=%0d", idx), 48'(done_cyc[1] - k), 48'(49 + P_B));
  endtask

  initial begin
    pos[0] = -1; pos[1] = -1;
    crc_exp[0] = 7'd0; crc_exp[1] = 7'd0;
    fr[0] = 48'd0; fr[1] = 48'd0;
    cap = 48'd0;
    done_cyc[0] = 0; done_cyc[1] = 0;

    // Reset state
    repeat (3) cycle();
    reset = 1'b1;
    repeat (2) cycle();

    // Reference commands
    known_frame(6'd0,  32'h0000_0000, 48'h40_0000_0000_95, 7'h4A);
    known_frame(6'd8,  32'h0000_01AA, 48'h48_0000_01AA_87, 7'h43);
    known_frame(6'd17, 32'h0000_0000, 48'h51_0000_0000_55, 7'h2A);

    // Start pulses during a frame (bit 47 and bit 20) must be ignored
    send(6'($urandom), $urandom);
    for (int n = 0; n < 200 && pos[0] >= 0; n++) begin
      start = (pos[0] == 1 || pos[0] == 28);
      cmd_index = 6'($urandom);
      cmd_arg = $urandom;
      cycle();
    end
    start = 1'b0;
    run_until_idle();

    // Start held across done: back-to-back frames
    start = 1'b1;
    for (int n = 0; n < 130; n++) begin
      cmd_index = 6'($urandom);
      cmd_arg = $urandom;
      cycle();
    end
    start = 1'b0;
    run_until_idle();

    // Asynchronous reset between edges while bit 30 is on the line
    send(6'($urandom), $urandom);
    for (int n = 0; n < 100 && pos[0] != 18; n++) cycle();
    #3;
    reset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("async rst dut%0d cmd_out", d), 48'(cmd_out[d]), 48'd1);
      chk($sformatf("async rst dut%0d cmd_oe", d), 48'(cmd_oe[d]), 48'd0);
      chk($sformatf("async rst dut%0d busy", d), 48'(busy[d]), 48'd0);
      chk($sformatf("async rst dut%0d crc_out", d), 48'(crc_out[d]), 48'd0);
      pos[d] = -1;
      crc_exp[d] = 7'd0;
    end
    repeat (2) cycle();
    reset = 1'b1;
    cycle();
    known_frame(6'd8, 32'h0000_01AA, 48'h48_0000_01AA_87, 7'h43);

    // Random traffic: sparse starts, inputs changing every cycle
    for (int n = 0; n < 1500; n++) begin
      start = ($urandom_range(0, 15) == 0);
      cmd_index = 6'($urandom);
      cmd_arg = $urandom;
      cycle();
    end
    start = 1'b0;
    run_until_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
